arm_emit_ctrl: RTL
==================

Name: arm_emit_ctrl

Overview:
- Sequencer between the translator state machine and the code RAM that receives generated ARM instructions.
- Accepts one 32-bit ARM instruction per cycle from the translator (valid_write / arm_inst) into a small FIFO. Drains the FIFO to code RAM through a req/gnt port, advancing the write address.
- Handles end-of-method flush and code-space overflow; backpressures the translator through in_ready, which feeds the translator's waiting input.

Parameters:
- ADDRESS_WIDTH, 16: code RAM word-address width.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, 2..16.
- BASE_ADDR, 0: word address of the first emitted instruction after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  translator presents an instruction this cycle.
- in_inst  in  32  ARM instruction word.
- in_ready  out  1  FIFO can accept; transfer happens when in_valid & in_ready.
- flush_req  in  1  single-cycle pulse: method complete; drain and report.
- flush_done  out  1  one-cycle pulse when drain is complete.
- mem_req  out  1  write request to code RAM.
- mem_addr  out  ADDRESS_WIDTH  word address of the write.
- mem_wdata  out  32  instruction data.
- mem_gnt  in  1  RAM accepts; a write completes when mem_req & mem_gnt.
- limit  in  ADDRESS_WIDTH  last writable word address; static while not IDLE.
- emit_count  out  ADDRESS_WIDTH  words written since the last flush_done.
- overflow  out  1  sticky error: write attempted beyond limit.

Behaviour:
- Reset values (asynchronous, reset low):
  - FIFO empty; in_ready=0, mem_req=0, flush_done=0, overflow=0, emit_count=0.
  - Write pointer = BASE_ADDR; state = IDLE.
- Reset low mid-operation discards FIFO contents and any pending write.
- IDLE:
  - Entered from reset; moves to RUN on the next cycle (in_ready rises on the first cycle after reset is released).
- RUN:
  - in_ready = !full.
  - mem_req = !empty; mem_addr = write pointer; mem_wdata = FIFO head.
  - On mem_req & mem_gnt: pop the head, pointer+1, emit_count+1.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full.
  - Latency: a word pushed into an empty FIFO raises mem_req on the next cycle. It is never written combinationally from in_inst.
- flush_req in RUN:
  - Go to DRAIN; in_ready=0 from the next cycle.
  - An instruction accepted in the same cycle as flush_req is kept and drained.
- DRAIN:
  - Pop as in RUN until the FIFO is empty, then go to DONE.
- DONE:
  - flush_done=1 for exactly one cycle.
  - emit_count clears on the following cycle. The pointer is NOT reset, so the next method is appended.
  - Return to RUN.
- Overflow:
  - If a pop would write at pointer > limit, suppress mem_req, set overflow, and enter ERR.
- ERR:
  - in_ready=0, mem_req=0.
  - Inputs are ignored except flush_req, which discards the FIFO, pulses flush_done, and holds the ERR state.
  - Only reset leaves ERR.
- Pointer arithmetic:
  - Unsigned, ADDRESS_WIDTH bits.
  - pointer == all-ones with limit == all-ones is the last legal write. The following increment wraps to 0 and sets overflow.
- flush_req outside RUN is ignored.
- mem_addr and mem_wdata are stable while mem_req=1 and mem_gnt=0.

Optional Feature:
- Macro: ARM_EMIT_NOP_PAD_EN.
- Defined: in DRAIN, once the FIFO is empty, if pointer[1:0] != 0, write NOP 32'hE1A00000 (mov r0,r0) until pointer[1:0]==0. Padding words count in emit_count and are subject to the limit check. This gives 16-byte alignment for each method.
- Undefined: no padding; DRAIN ends on FIFO empty.

Decomposition:
- me_consts.vh holds:
  - state encodings EMIT_IDLE/RUN/DRAIN/DONE/ERR and width EMIT_SMNL;
  - ARM_NOP constant;
  - shared ADDRESS_WIDTH.
- Sub-module emit_fifo: synchronous FIFO with parameters DEPTH and WIDTH=32, ports push/pop/full/empty/head. It uses the same asynchronous active-low reset.

Test Plan:
- Streaming: reset low then high, mem_gnt=1, push 0xE3A00001, 0xE52D0004, 0xE3A00002 on consecutive cycles -> writes at addr 0,1,2 in order, one cycle after each push; emit_count=3.
- Backpressure: mem_gnt=0, push 5 words with FIFO_DEPTH=4 -> in_ready=0 after 4; 5th held by translator; release gnt -> all 5 written, addr 0..4.
- Flush: 2 words pending, flush_req pulsed in the same cycle as a 3rd push -> 3 writes, then flush_done one cycle, emit_count 3 then 0, next push written at addr 3.
- Overflow: limit=2, push 4 words -> writes at 0..2, overflow=1, no write to addr 3, in_ready=0 until reset.
- Reset mid-drain: 3 words queued, gnt=0, reset low -> mem_req=0 immediately, FIFO empty, pointer=BASE_ADDR.
- NOP pad (ARM_EMIT_NOP_PAD_EN): 5 words then flush -> addr 5,6,7 written with 0xE1A00000, flush_done, emit_count=8.

Source files
------------

// File: rtl/arm_emit_ctrl_pkg.sv
// Shared definitions for the ARM instruction emit sequencer:
// sequencer state encoding, the NOP pad word and the default code-RAM
// address width.
package arm_emit_ctrl_pkg;

  localparam int EMIT_SMNL = 3;

  typedef enum logic [EMIT_SMNL-1:0] {
    EMIT_IDLE  = 3'd0,
    EMIT_RUN   = 3'd1,
    EMIT_DRAIN = 3'd2,
    EMIT_DONE  = 3'd3,
    EMIT_ERR   = 3'd4
  } emit_state_e;

  // mov r0,r0 -- the canonical ARM no-op used for alignment padding
  localparam logic [31:0] ARM_NOP = 32'hE1A00000;

  localparam int EMIT_ADDRESS_WIDTH = 16;

endpackage

// File: rtl/arm_emit_ctrl_emit_fifo.sv
// Small synchronous instruction FIFO between the translator and code RAM.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
// Push and pop may occur together, including while full. The clear input
// discards all queued entries. Storage is not reset; only occupancy is.
module arm_emit_ctrl_emit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage: written on accepted push, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Occupancy tracking: pointers and entry count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arm_emit_ctrl.sv
// ARM instruction emit sequencer: buffers translator output in a FIFO and
// writes it word by word into code RAM over a req/gnt port, handling
// end-of-method flush and code-space overflow.
// Optional build macro ARM_EMIT_NOP_PAD_EN: on flush, pad the method with
// NOPs up to a 16-byte boundary before reporting flush_done.
module arm_emit_ctrl
  import arm_emit_ctrl_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = EMIT_ADDRESS_WIDTH,
  parameter int                       FIFO_DEPTH    = 4,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_inst,
  output logic                     in_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     mem_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_gnt,
  input  logic [ADDRESS_WIDTH-1:0] limit,
  output logic [ADDRESS_WIDTH-1:0] emit_count,
  output logic                     overflow
);

  emit_state_e              state;
  emit_state_e              state_nxt;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic [ADDRESS_WIDTH-1:0] count;
  logic                     ovf;
  logic                     err_done;

  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic        fifo_clear;
  logic        push;
  logic        pop;

  logic active;
  logic pad;
  logic attempt;
  logic beyond;
  logic wr_done;
  logic wrap;
  logic ovf_hit;

  arm_emit_ctrl_emit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (fifo_clear),
    .push  (push),
    .din   (in_inst),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign active = (state == EMIT_RUN) || (state == EMIT_DRAIN);

`ifdef ARM_EMIT_NOP_PAD_EN
  // Once the buffer has drained, keep writing NOPs until 16-byte aligned
  assign pad = (state == EMIT_DRAIN) && fifo_empty && (ptr[1:0] != 2'b00);
`else
  assign pad = 1'b0;
`endif

  // A write is wanted whenever a word (or pad NOP) is ready; the limit
  // check turns a wanted write past the end of code space into an error
  assign attempt = (active && !fifo_empty) || pad;
  assign beyond  = (ptr > limit);
  assign wr_done = mem_req && mem_gnt;
  // Completing the write at the all-ones address leaves nowhere to go next
  assign wrap    = wr_done && (ptr == '1);
  assign ovf_hit = (attempt && beyond) || wrap;

  assign mem_req    = attempt && !beyond;
  assign mem_addr   = ptr;
  assign mem_wdata  = pad ? ARM_NOP : fifo_head;
  assign pop        = wr_done && !pad;
  assign in_ready   = (state == EMIT_RUN) && !fifo_full;
  assign push       = in_valid && in_ready;
  assign fifo_clear = (state == EMIT_ERR) && flush_req;
  assign flush_done = (state == EMIT_DONE) || err_done;
  assign emit_count = count;
  assign overflow   = ovf;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMIT_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: flush moves RUN to DRAIN, overflow traps in ERR until reset
  always_comb begin
    state_nxt = state;
    case (state)
      EMIT_IDLE: state_nxt = EMIT_RUN;
      EMIT_RUN: begin
        if (ovf_hit)        state_nxt = EMIT_ERR;
        else if (flush_req) state_nxt = EMIT_DRAIN;
      end
      EMIT_DRAIN: begin
        if (ovf_hit)       state_nxt = EMIT_ERR;
        else if (!attempt) state_nxt = EMIT_DONE;
      end
      EMIT_DONE: state_nxt = EMIT_RUN;
      EMIT_ERR:  state_nxt = EMIT_ERR;
      default:   state_nxt = EMIT_IDLE;
    endcase
  end

  // Write pointer, per-method word count, sticky overflow, ERR flush pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= BASE_ADDR;
      count    <= '0;
      ovf      <= 1'b0;
      err_done <= 1'b0;
    end else begin
      if (wr_done) ptr <= ptr + 1'b1;
      if (flush_done)   count <= '0;
      else if (wr_done) count <= count + 1'b1;
      if (active && ovf_hit) ovf <= 1'b1;
      err_done <= fifo_clear;
    end
  end

endmodule
